// File: rtl/trdb_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module  : trdb_packet_decoder (with trdb_pkg)
// Brief   : Deframes trace packets, re-expands sign-compressed payloads and
//           rebuilds absolute instruction addresses.
// Revision: 1.0 - initial release
// ============================================================================

package trdb_pkg;
    parameter int XLEN = 32;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2,
        SF_SUPPORT = 2'd3
    } trdb_f_sync_subformat_e;
endpackage

module trdb_packet_decoder
    import trdb_pkg::*;
#(
    parameter int XLEN              = trdb_pkg::XLEN,
    parameter int MAX_PAYLOAD_BYTES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_full_addr_i,
    input  logic                   in_valid_i,
    input  logic [7:0]             in_data_i,
    output logic                   in_ready_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output trdb_format_e           packet_format_o,
    output trdb_f_sync_subformat_e packet_f_sync_subformat_o,
    output logic [4:0]             payload_len_o,
    output logic [4:0]             branches_o,
    output logic [30:0]            branch_map_o,
    output logic                   branch_o,
    output logic [1:0]             priv_o,
    output logic                   addr_valid_o,
    output logic [XLEN-1:0]        addr_o,
    output logic                   error_o
);
    localparam int c_PW   = 8 * MAX_PAYLOAD_BYTES;
    localparam int c_IDXW = $clog2(c_PW);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_DECODE  = 2'd2,
        S_OUT     = 2'd3
    } state_e;

    state_e                 r_state;
    logic [c_PW-1:0]        r_buf;
    logic [4:0]             r_len;
    logic [4:0]             r_cnt;
    logic                   r_discard;
    logic [XLEN-1:0]        r_last_addr;
    logic                   r_out_valid;
    trdb_format_e           r_format;
    trdb_f_sync_subformat_e r_subformat;
    logic [4:0]             r_payload_len;
    logic [4:0]             r_branches;
    logic [30:0]            r_branch_map;
    logic                   r_branch;
    logic [1:0]             r_priv;
    logic                   r_addr_valid;
    logic [XLEN-1:0]        r_addr;
    logic                   r_error;

    logic [7:0]             w_nbits;
    logic [c_IDXW-1:0]      w_sign_idx;
    logic [c_PW-1:0]        w_mask;
    logic [c_PW-1:0]        w_ext;
    trdb_format_e           w_fmt;
    trdb_f_sync_subformat_e w_sf;
    trdb_f_sync_subformat_e w_sf_out;
    logic [4:0]             w_branches;
    logic [4:0]             w_branches_out;
    logic [5:0]             w_map_w;
    logic [6:0]             w_shamt;
    logic [30:0]            w_map_out;
    logic                   w_branch;
    logic [1:0]             w_priv;
    logic [XLEN-1:0]        w_field;
    logic                   w_has_addr;
    logic                   w_diff;
    logic [XLEN-1:0]        w_addr;
    logic                   w_unused;

    assign w_unused   = ^in_data_i[7:5];
    assign w_nbits    = {r_len, 3'b000};
    // Index of the payload's top bit, i.e. 8*L-1.
    assign w_sign_idx = c_IDXW'({r_len, 3'b111} - 8'd8);

    always_comb begin
        w_mask         = ~({c_PW{1'b1}} << w_nbits);
        w_ext          = (r_buf & w_mask) | ({c_PW{r_buf[w_sign_idx]}} & ~w_mask);
        w_fmt          = trdb_format_e'(w_ext[1:0]);
        w_sf           = trdb_f_sync_subformat_e'(w_ext[3:2]);
        w_branches     = w_ext[6:2];
        w_sf_out       = SF_START;
        w_branches_out = 5'd0;
        w_map_out      = 31'd0;
        w_branch       = 1'b0;
        w_priv         = 2'd0;
        w_field        = '0;
        w_has_addr     = 1'b0;
        w_diff         = 1'b0;

        if (w_branches == 5'd0)       w_map_w = 6'd31;
        else if (w_branches == 5'd1)  w_map_w = 6'd1;
        else if (w_branches <= 5'd9)  w_map_w = 6'd9;
        else if (w_branches <= 5'd17) w_map_w = 6'd17;
        else if (w_branches <= 5'd25) w_map_w = 6'd25;
        else                          w_map_w = 6'd31;
        w_shamt = 7'd7 + 7'(w_map_w);

        case (w_fmt)
            F_ADDR_ONLY: begin
                w_field    = XLEN'(w_ext >> 2);
                w_has_addr = 1'b1;
                w_diff     = 1'b1;
            end
            F_DIFF_DELTA: begin
                w_branches_out = w_branches;
                w_map_out      = w_ext[37:7] & ~(31'h7FFF_FFFF << w_map_w);
                if (w_branches != 5'd0) begin
                    w_field    = XLEN'(w_ext >> w_shamt);
                    w_has_addr = 1'b1;
                    w_diff     = 1'b1;
                end
            end
            F_SYNC: begin
                w_sf_out = w_sf;
                if (w_sf == SF_START) begin
                    w_branch   = w_ext[4];
                    w_priv     = w_ext[6:5];
                    w_field    = XLEN'(w_ext >> 7);
                    w_has_addr = 1'b1;
                end
            end
            default: ;
        endcase

        w_addr = (w_diff && !cfg_full_addr_i) ? (r_last_addr + w_field) : w_field;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_buf         <= '0;
            r_len         <= 5'd0;
            r_cnt         <= 5'd0;
            r_discard     <= 1'b0;
            r_last_addr   <= '0;
            r_out_valid   <= 1'b0;
            r_format      <= F_OPT_EXT;
            r_subformat   <= SF_START;
            r_payload_len <= 5'd0;
            r_branches    <= 5'd0;
            r_branch_map  <= 31'd0;
            r_branch      <= 1'b0;
            r_priv        <= 2'd0;
            r_addr_valid  <= 1'b0;
            r_addr        <= '0;
            r_error       <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        if (in_data_i[4:0] == 5'd0) begin
                            r_error <= 1'b1;
                        end else begin
                            r_len     <= in_data_i[4:0];
                            r_cnt     <= 5'd0;
                            r_discard <= (in_data_i[4:0] > 5'(MAX_PAYLOAD_BYTES));
                            r_buf     <= '0;
                            r_state   <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (in_valid_i) begin
                        if (!r_discard) begin
                            r_buf[c_IDXW'({r_cnt, 3'b000}) +: 8] <= in_data_i;
                        end
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == r_len - 5'd1) begin
                            if (r_discard) begin
                                r_error <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_DECODE;
                            end
                        end
                    end
                end
                S_DECODE: begin
                    r_format      <= w_fmt;
                    r_subformat   <= w_sf_out;
                    r_payload_len <= r_len;
                    r_branches    <= w_branches_out;
                    r_branch_map  <= w_map_out;
                    r_branch      <= w_branch;
                    r_priv        <= w_priv;
                    r_addr_valid  <= w_has_addr;
                    r_addr        <= w_has_addr ? w_addr : '0;
                    if (w_has_addr) begin
                        r_last_addr <= w_addr;
                    end
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    // Fields settle one cycle before valid is raised.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o                = (r_state == S_IDLE) || (r_state == S_PAYLOAD);
    assign out_valid_o               = r_out_valid;
    assign packet_format_o           = r_format;
    assign packet_f_sync_subformat_o = r_subformat;
    assign payload_len_o             = r_payload_len;
    assign branches_o                = r_branches;
    assign branch_map_o              = r_branch_map;
    assign branch_o                  = r_branch;
    assign priv_o                    = r_priv;
    assign addr_valid_o              = r_addr_valid;
    assign addr_o                    = r_addr;
    assign error_o                   = r_error;

endmodule

`default_nettype wire

// File: tb/tb_trdb_packet_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_trdb_packet_decoder
// Brief   : Randomized and directed bench for trdb_packet_decoder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_trdb_packet_decoder;
    import trdb_pkg::*;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [1:0]  sf;
        logic [4:0]  len;
        logic [4:0]  branches;
        logic [30:0] map;
        logic        branch;
        logic [1:0]  priv;
        logic        av;
        logic [31:0] addr;
    } rec_t;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   cfg_full_addr_i;
    logic                   in_valid_i;
    logic [7:0]             in_data_i;
    logic                   in_ready_o;
    logic                   out_valid_o;
    logic                   out_ready_i;
    trdb_format_e           packet_format_o;
    trdb_f_sync_subformat_e packet_f_sync_subformat_o;
    logic [4:0]             payload_len_o;
    logic [4:0]             branches_o;
    logic [30:0]            branch_map_o;
    logic                   branch_o;
    logic [1:0]             priv_o;
    logic                   addr_valid_o;
    logic [31:0]            addr_o;
    logic                   error_o;

    trdb_packet_decoder #(.XLEN(32), .MAX_PAYLOAD_BYTES(16)) dut (
        .clk_i                     (clk_i),
        .rst_i                     (rst_i),
        .cfg_full_addr_i           (cfg_full_addr_i),
        .in_valid_i                (in_valid_i),
        .in_data_i                 (in_data_i),
        .in_ready_o                (in_ready_o),
        .out_valid_o               (out_valid_o),
        .out_ready_i               (out_ready_i),
        .packet_format_o           (packet_format_o),
        .packet_f_sync_subformat_o (packet_f_sync_subformat_o),
        .payload_len_o             (payload_len_o),
        .branches_o                (branches_o),
        .branch_map_o              (branch_map_o),
        .branch_o                  (branch_o),
        .priv_o                    (priv_o),
        .addr_valid_o              (addr_valid_o),
        .addr_o                    (addr_o),
        .error_o                   (error_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_err  = 0;
    int          err_seen = 0;
    bit          bp_hold  = 1'b0;
    logic [7:0]  pkt[$];
    rec_t        exp_q[$];
    logic [31:0] m_last   = '0;

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    function automatic logic [63:0] bits(input logic [255:0] p, input int lo, input int n);
        logic [63:0] v = '0;
        for (int k = 0; k < n; k++) v[k] = p[lo + k];
        return v;
    endfunction

    function automatic int map_width(input int b);
        int w;
        if (b == 0) return 31;
        if (b == 1) return 1;
        w = ((b - 2) / 8) * 8 + 9;
        return (w > 31) ? 31 : w;
    endfunction

    // Reference decode of the packet currently in pkt (header + payload).
    task automatic model_packet(output rec_t r);
        logic [255:0] p;
        logic [31:0]  field;
        int           len;
        int           w;
        r   = '0;
        p   = '0;
        len = pkt.size() - 1;
        for (int i = 0; i < len; i++) p[8*i +: 8] = pkt[i+1];
        for (int j = 8*len; j < 256; j++) p[j] = p[8*len-1];
        r.len = 5'(len);
        r.fmt = 2'(bits(p, 0, 2));
        case (r.fmt)
            2'd2: begin
                field  = 32'(bits(p, 2, 32));
                r.av   = 1'b1;
                r.addr = cfg_full_addr_i ? field : m_last + field;
            end
            2'd1: begin
                r.branches = 5'(bits(p, 2, 5));
                w          = map_width(int'(r.branches));
                r.map      = 31'(bits(p, 7, w));
                if (r.branches != 0) begin
                    field  = 32'(bits(p, 7 + w, 32));
                    r.av   = 1'b1;
                    r.addr = cfg_full_addr_i ? field : m_last + field;
                end
            end
            2'd3: begin
                r.sf = 2'(bits(p, 2, 2));
                if (r.sf == 2'd0) begin
                    r.branch = p[4];
                    r.priv   = 2'(bits(p, 5, 2));
                    r.addr   = 32'(bits(p, 7, 32));
                    r.av     = 1'b1;
                end
            end
            default: ;
        endcase
        if (r.av) m_last = r.addr;
    endtask

    // Output monitor and consumer.
    initial begin
        rec_t a;
        out_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (error_o) err_seen++;
                if (out_valid_o) begin
                    a.fmt = packet_format_o;       a.sf = packet_f_sync_subformat_o;
                    a.len = payload_len_o;         a.branches = branches_o;
                    a.map = branch_map_o;          a.branch = branch_o;
                    a.priv = priv_o;               a.av = addr_valid_o;
                    a.addr = addr_o;
                    if (exp_q.size() == 0) check(1'b0, "unexpected_pkt", a, '0);
                    else check(a === exp_q[0], "pkt_out", a, exp_q[0]);
                    check(in_ready_o === 1'b0, "in_ready_busy", in_ready_o, 0);
                end
            end
            out_ready_i = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (!rst_i && out_valid_o && out_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    task automatic send_pkt();
        int n;
        bit done;
        for (int i = 0; i < pkt.size(); i++) begin
            in_valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
            in_valid_i = 1'b1;
            in_data_i  = pkt[i];
            n    = 0;
            done = 1'b0;
            while (!done) begin
                if (in_ready_o) done = 1'b1;
                @(posedge clk_i); #1;
                n++;
                if (!done && n > 200) begin
                    check(1'b0, "in_ready_timeout", in_ready_o, 1);
                    in_valid_i = 1'b0;
                    return;
                end
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin @(posedge clk_i); #1; n++; end
        check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_valid(input bit bp, output rec_t r);
        model_packet(r);
        exp_q.push_back(r);
        bp_hold = bp;
        send_pkt();
        check(out_valid_o === 1'b0, "latency_e0", out_valid_o, 0);
        @(posedge clk_i); #1;
        check(out_valid_o === 1'b0, "latency_e1", out_valid_o, 0);
        @(posedge clk_i); #1;
        check(out_valid_o === 1'b1, "latency_e2", out_valid_o, 1);
        if (bp) begin
            for (int c = 0; c < 5; c++) begin
                check({out_valid_o, in_ready_o} === 2'b10, "backpressure", {out_valid_o, in_ready_o}, 2'b10);
                @(posedge clk_i); #1;
            end
            bp_hold = 1'b0;
        end
        wait_drain();
    endtask

    task automatic do_err();
        exp_err++;
        send_pkt();
        check(error_o === 1'b1, "err_pulse", error_o, 1);
        @(posedge clk_i); #1;
        check({error_o, out_valid_o} === 2'b00, "err_end", {error_o, out_valid_o}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        rec_t r;
        int   len;
        logic [7:0] b0;
        rst_i = 1'b1; cfg_full_addr_i = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check({out_valid_o, in_ready_o, addr_valid_o, error_o, branch_o} === 5'b01000,
              "reset_ctl", {out_valid_o, in_ready_o, addr_valid_o, error_o, branch_o}, 5'b01000);
        check(addr_o === 32'h0 && payload_len_o === 5'd0 && branches_o === 5'd0, "reset_data",
              {addr_o, payload_len_o, branches_o}, 0);
        check(branch_map_o === 31'd0 && priv_o === 2'd0 && packet_format_o === F_OPT_EXT
              && packet_f_sync_subformat_o === SF_START, "reset_fields",
              {branch_map_o, priv_o, packet_format_o, packet_f_sync_subformat_o}, 0);

        cfg_full_addr_i = 1'b1; pkt = '{8'h02, 8'h12, 8'h34}; do_valid(1'b0, r);
        check(r.addr === 32'h0000_0D04 && r.fmt == 2'd2 && r.len == 5'd2 && r.av, "model_addr_only", r.addr, 32'hD04);

        cfg_full_addr_i = 1'b0; pkt = '{8'h02, 8'hFE, 8'hFF}; do_valid(1'b0, r);
        check(r.addr === 32'h0000_0D03 && r.av, "model_diff_neg", r.addr, 32'hD03);

        pkt = '{8'h05, 8'h33, 8'h00, 8'h00, 8'h00, 8'h40}; do_valid(1'b0, r);
        check(r.fmt == 2'd3 && r.sf == 2'd0 && r.branch && r.priv == 2'd1 && r.addr === 32'h8000_0000,
              "model_sync_start", r, 32'h8000_0000);

        pkt = '{8'h02, 8'h8D, 8'h02}; do_valid(1'b0, r);
        check(r.fmt == 2'd1 && r.branches == 5'd3 && r.map == 31'h5 && r.av && r.addr === 32'h8000_0000,
              "model_diff_delta", r, 32'h8000_0000);

        pkt = '{8'h00}; do_err();
        pkt = '{8'h14};
        repeat (20) pkt.push_back(8'($urandom));
        do_err();

        cfg_full_addr_i = 1'b1; pkt = '{8'h02, 8'h12, 8'h34}; do_valid(1'b0, r);
        check(r.addr === 32'h0000_0D04, "model_after_discard", r.addr, 32'hD04);

        pkt = '{8'h02, 8'h12, 8'h34}; do_valid(1'b1, r);

        // Reset in the middle of a payload, with a byte offered during reset.
        pkt = '{8'h05, 8'h33, 8'h00}; send_pkt();
        rst_i = 1'b1; in_valid_i = 1'b1; in_data_i = 8'h03;
        @(posedge clk_i); #1;
        rst_i = 1'b0; in_valid_i = 1'b0;
        check({out_valid_o, in_ready_o, addr_valid_o, error_o} === 4'b0100, "midreset_ctl",
              {out_valid_o, in_ready_o, addr_valid_o, error_o}, 4'b0100);
        check(addr_o === 32'h0 && payload_len_o === 5'd0, "midreset_data", {addr_o, payload_len_o}, 0);
        exp_q.delete(); m_last = '0;
        cfg_full_addr_i = 1'b0; pkt = '{8'h02, 8'hFE, 8'hFF}; do_valid(1'b0, r);
        check(r.addr === 32'hFFFF_FFFF, "model_last_addr_reset", r.addr, 32'hFFFF_FFFF);

        for (int k = 0; k < 80; k++) begin
            cfg_full_addr_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(17, 31);
                pkt = '{};
                pkt.push_back({3'($urandom), 5'(len)});
                repeat (len) pkt.push_back(8'($urandom));
                do_err();
            end else begin
                len = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 5) : $urandom_range(1, 16);
                b0  = 8'($urandom);
                b0[1:0] = 2'($urandom_range(0, 3));
                if (b0[1:0] == 2'd3 && $urandom_range(0, 1) != 0) b0[3:2] = 2'd0;
                pkt = '{};
                pkt.push_back({3'($urandom), 5'(len)});
                pkt.push_back(b0);
                repeat (len - 1) pkt.push_back(8'($urandom));
                do_valid(1'b0, r);
            end
        end

        wait_drain();
        check(err_seen == exp_err, "err_count", err_seen, exp_err);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trdb_packet_decoder.md
Name: trdb_packet_decoder

Overview:
- Decoder-side counterpart of the trace encoder's packet selector and compressor.
- Accepts the framed byte stream produced by the packet emitter and recovers format, subformat and fields. Re-expands sign-compressed payloads and reconstructs absolute instruction addresses (differential or full mode).
- Sits at the front of the trace decoder/checker, feeding the instruction-path reconstruction model.

Parameters:
- XLEN, 32, address width; the same value as trdb_pkg.
- MAX_PAYLOAD_BYTES, 16, payload buffer depth in bytes. Payload bit width PW = 8*MAX_PAYLOAD_BYTES; PW >= XLEN+39.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- cfg_full_addr_i  in  1  1 = addresses are absolute; 0 = F1/F2 addresses are differential.
- in_valid_i  in  1  byte valid.
- in_data_i  in  8  stream byte.
- in_ready_o  out  1  byte accepted when in_valid_i && in_ready_o.
- out_valid_o  out  1  decoded packet available.
- out_ready_i  in  1  consumer accepts the packet.
- packet_format_o  out  trdb_format_e  payload[1:0].
- packet_f_sync_subformat_o  out  trdb_f_sync_subformat_e  payload[3:2]; 0 unless format is F_SYNC.
- payload_len_o  out  5  payload byte count.
- branches_o  out  5  F_DIFF_DELTA branch count.
- branch_map_o  out  31  F_DIFF_DELTA branch map, zero-padded.
- branch_o  out  1  F_SYNC SF_START branch bit.
- priv_o  out  2  F_SYNC SF_START privilege.
- addr_valid_o  out  1  addr_o carries a decoded address.
- addr_o  out  XLEN  reconstructed address.
- error_o  out  1  one-cycle pulse on a framing error.

Behaviour:
- Framing:
  - Header byte [4:0] = payload length L in bytes; [7:5] ignored.
  - Then L payload bytes, LSB first.
- FSM states: IDLE (await header) -> PAYLOAD (collect L bytes) -> DECODE (1 cycle) -> OUT (hold until out_ready_i) -> IDLE.
- in_ready_o = 1 in IDLE and PAYLOAD, 0 in DECODE and OUT. No pipelining across packets.
- Header L=0: pulse error_o the next cycle, stay IDLE, no packet.
- Header L>MAX_PAYLOAD_BYTES: enter PAYLOAD in discard mode and consume L bytes without storing. Pulse error_o the cycle after the last byte, return to IDLE, no packet.
- Sign extension: ext[PW-1:0] = payload bits [8L-1:0], with bits >= 8L filled with bit 8L-1. All field extraction uses ext.
- F_ADDR_ONLY:
  - field = ext[2 +: XLEN].
  - addr_valid_o = 1.
- F_DIFF_DELTA:
  - branches = ext[6:2].
  - Map width W: 0->31, 1->1, 2..9->9, 10..17->17, 18..25->25, 26..31->31.
  - branch_map = ext[7 +: W], zero-extended to 31 bits.
  - branches=0: no address, addr_valid_o = 0.
  - Otherwise field = ext[(7+W) +: XLEN] and addr_valid_o = 1.
- F_SYNC SF_START:
  - branch = ext[4], priv = ext[6:5].
  - addr = ext[7 +: XLEN], always absolute.
  - addr_valid_o = 1.
- Other F_SYNC subformats and F_OPT_EXT: format/subformat/len only, addr_valid_o = 0, last_addr unchanged.
- Address reconstruction:
  - For F1/F2, addr = cfg_full_addr_i ? field : last_addr + field, modulo 2^XLEN.
  - last_addr updates to addr in DECODE whenever addr_valid is set.
- Latency: out_valid_o rises on the 2nd rising edge after the edge that accepted the last payload byte.
- Handshake: all outputs stay stable while out_valid_o && !out_ready_i. Transfer happens on out_valid_o && out_ready_i, after which the FSM returns to IDLE the following cycle.
- Reset (rst_i sampled high at an edge):
  - state IDLE, last_addr 0, buffer cleared.
  - All outputs 0 except in_ready_o = 1.
  - A partially received packet is discarded; bytes presented while rst_i is high are ignored.

Test Plan:
- Reset, cfg_full_addr_i=1; send header 0x02, bytes 0x12 0x34 -> F_ADDR_ONLY, len 2, addr 0x00000D04, addr_valid 1.
- Then cfg_full_addr_i=0; send header 0x02, bytes 0xFE 0xFF -> field 0xFFFFFFFF, addr = 0x00000D04 - 1 = 0x00000D03.
- Send header 0x05, bytes 33 00 00 00 40 -> F_SYNC SF_START, branch 1, priv 1, addr 0x80000000; last_addr becomes 0x80000000.
- cfg_full_addr_i=0; send header 0x02, bytes 0x8D 0x02 -> F_DIFF_DELTA, branches 3, branch_map 0x005, field 0, addr 0x80000000.
- Send header 0x00 -> error_o one cycle, no out_valid_o. Send header 0x14 plus 20 bytes (MAX=16) -> error_o after the 20th byte, no packet; a next valid packet decodes correctly.
- Backpressure: hold out_ready_i=0 for 5 cycles after out_valid_o -> outputs stable, in_ready_o=0. Assert rst_i mid-PAYLOAD -> IDLE, outputs 0, last_addr 0.
